// File: rtl/pipe_ctrl.sv
// Pipeline control for the N-stage in-order core: merges per-stage stall requests
// into the stall bus and sequences exception flush / PC redirect to the fetch stage.
module pipe_ctrl #(
  parameter int NSTAGE  = 5,
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              exc_req,
  input  logic [PC_W-1:0]   exc_pc,
  output logic [NSTAGE:0]   stall,
  output logic [NSTAGE-1:0] flush,
  output logic              new_pc_valid,
  output logic [PC_W-1:0]   new_pc,
  input  logic              new_pc_ready,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_in_run;
  logic              w_any_req;
  logic              w_exc_take;
  logic              w_handshake;
  logic              w_run_stall;
  logic              w_seen;
  logic [NSTAGE:0]   w_stall_merge;
  logic [TO_W-1:0]   r_wd;
  logic [TO_W-1:0]   w_wd_nxt;
  logic [NSTAGE-1:0] r_flush;
  logic              r_new_pc_valid;
  logic [PC_W-1:0]   r_new_pc;
  logic              r_stall_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;

  assign w_in_run    = (r_state == S_RUN);
  assign w_any_req   = |stallreq;
  assign w_exc_take  = w_in_run & exc_req;
  assign w_handshake = r_new_pc_valid & new_pc_ready;
  assign w_run_stall = w_in_run & w_any_req;

  // Stall the requesting stage and everything upstream of it, down to the PC.
  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_seen        = 1'b0;
    w_stall_merge = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      w_seen             = w_seen | stallreq[i];
      w_stall_merge[i+1] = w_seen;
    end
    w_stall_merge[0] = w_seen;
  end

  assign stall = w_in_run ? w_stall_merge : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (exc_req) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_REDIR;
      S_REDIR: if (w_handshake) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Watchdog measures the current unbroken run of stalled RUN cycles.
  always_comb begin
    w_wd_nxt = r_wd;
    if (w_exc_take) begin
      w_wd_nxt = '0;
    end else if (w_in_run) begin
      if (!w_any_req)            w_wd_nxt = '0;
      else if (r_wd != TO_LIMIT) w_wd_nxt = r_wd + TO_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_RUN;
      r_flush        <= '0;
      r_new_pc_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_flush        <= {NSTAGE{w_state_nxt != S_RUN}};
      r_new_pc_valid <= (w_state_nxt == S_REDIR);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_new_pc <= '0;
    end else if (w_exc_take) begin
      r_new_pc <= exc_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd            <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_wd <= w_wd_nxt;
      if (w_exc_take) begin
        r_stall_timeout <= 1'b0;
      end else if (w_run_stall && (w_wd_nxt == TO_LIMIT)) begin
        r_stall_timeout <= 1'b1;
      end
    end
  end

  // Performance counter survives flushes and wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
    end else if (w_run_stall) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign flush         = r_flush;
  assign new_pc_valid  = r_new_pc_valid;
  assign new_pc        = r_new_pc;
  assign stall_timeout = r_stall_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline control unit for the N-stage in-order core. It replaces the fixed two-source, combinational-only stall controller. It merges per-stage stall requests into the stall bus and adds a sequential exception-flush/redirect state machine with a ready/valid handshake to the fetch stage. It also provides a stuck-stall watchdog and a stall-cycle performance counter. It sits beside the pipeline at core top level, fed by every stage and driving every pipeline register.

Parameters:
NSTAGE, 5, number of pipeline stages (IF, ID, EX, MEM, WB); minimum 2
PC_W, 32, program-counter width
TIMEOUT, 255, consecutive stall cycles before watchdog fires; range 1..2^TO_W-1
TO_W, 8, watchdog counter width
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
stallreq  in  NSTAGE  bit i = stall request from stage i (0=IF ... NSTAGE-1=WB)
exc_req  in  1  exception/flush request, single-cycle pulse
exc_pc  in  PC_W  handler/redirect address, valid with exc_req
stall  out  NSTAGE+1  bit 0 = hold PC; bit k = hold stage register k (IF/ID=1 ...)
flush  out  NSTAGE  bit k = clear stage register k+1 to bubble
new_pc_valid  out  1  redirect address valid to IF
new_pc  out  PC_W  redirect address
new_pc_ready  in  1  IF accepts new_pc
stall_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  count of stalled RUN cycles

Behaviour:
- Reset (rst=0, async): state=RUN; stall=0, flush=0, new_pc_valid=0, new_pc=0, stall_timeout=0, watchdog=0, stall_cycles=0. Effect is immediate, from any state.
- stall is combinational in RUN. Let h = highest i with stallreq[i]=1; then stall[h+1:0]=all ones and higher bits are 0. No request gives stall=0.
- A bubble into register h+2 is implied: stall[h+1]=1 with stall[h+2]=0. Stages handle this; no extra output is required.
- FSM states: RUN, FLUSH, REDIR.
- RUN: exc_req=1 captures exc_pc into new_pc and sets next=FLUSH. stall is still driven from stallreq in that cycle.
- FLUSH (exactly 1 cycle): flush=all ones, stall=0. stallreq and exc_req are ignored. next=REDIR.
- REDIR: new_pc_valid=1, new_pc stable, flush=all ones, stall=0. stallreq and exc_req are ignored. A cycle with new_pc_valid & new_pc_ready is the handshake; next=RUN, and new_pc_valid=0 from that edge.
- The handshake may complete in the first REDIR cycle. The minimum exception-to-RUN time is 2 cycles.
- In RUN, flush=0 and new_pc_valid=0.
- Watchdog: counts consecutive RUN cycles with |stallreq. It clears on any RUN cycle without a request and on entering FLUSH, and saturates at TIMEOUT. Reaching TIMEOUT sets stall_timeout on the next edge. The flag stays set until reset or until FLUSH entry.
- stall_cycles: increments on every RUN cycle with |stallreq and wraps modulo 2^CNT_W. It is not cleared by flush.
- exc_req coincident with stallreq in RUN: the exception is accepted, and the stall for that cycle still applies.
- All outputs except stall are registered. stall is combinational from stallreq and state.

Test Plan:
- Reset: rst low, then high -> stall=6'b0, flush=5'b0, new_pc_valid=0, stall_timeout=0, stall_cycles=0.
- Stall merge (NSTAGE=5): stallreq=5'b00010 -> stall=6'b000111 same cycle. stallreq=5'b00110 -> 6'b001111. stallreq=5'b10000 -> 6'b111111. stallreq=0 -> 6'b0.
- Exception: exc_req pulse with exc_pc=32'hBFC00380 -> next cycle flush=5'b11111, stall=0. Following cycle new_pc_valid=1, new_pc=32'hBFC00380. Hold new_pc_ready=0 for 3 cycles -> outputs held. Set ready=1 -> next cycle RUN, flush=0, valid=0. exc_req pulsed during REDIR -> ignored.
- Watchdog (TIMEOUT=8): stallreq=5'b00100 for 8 cycles -> stall_timeout=1, stall_cycles=8. Drop the request -> flag stays 1. Then exc_req -> flag 0 after FLUSH entry.
- Counter wrap (CNT_W=4): 16 stalled RUN cycles -> stall_cycles=0. Stall cycles during FLUSH/REDIR are not counted.
- Async reset mid-REDIR: drive rst=0 between edges -> new_pc_valid and flush drop to 0 immediately. After release, state=RUN.
